// File: rtl/sram_like_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared encodings for the inst/data sram-like arbiter:
//   - FSM state encoding (ARB_IDLE / ARB_REQ / ARB_DATA)
//   - bus owner encoding (OWN_NONE / OWN_INST / OWN_DATA)
//   - sram_cmd_t: the request fields that travel together from a requester
//     to the merged master port, plus a helper to bundle them.
// -----------------------------------------------------------------------------
package sram_like_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

    function automatic sram_cmd_t make_cmd(input logic        wr,
                                           input logic [1:0]  size,
                                           input logic [31:0] addr,
                                           input logic [31:0] wdata);
        sram_cmd_t c;
        c.wr    = wr;
        c.size  = size;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_pick.sv
// -----------------------------------------------------------------------------
// sram_like_arb_pick
// Combinational grant select used while the arbiter is idle.
// Data has fixed priority, except when inst has been waiting through
// MAX_DATA_GRANTS consecutive data grants, in which case inst is forced.
// MAX_DATA_GRANTS = 0 disables the guard (pure data priority).
// Ports:
//   inst_req, data_req : pending requests
//   consec             : consecutive data grants taken while inst was waiting
//   pick               : OWN_NONE / OWN_INST / OWN_DATA
// -----------------------------------------------------------------------------
module sram_like_arb_pick
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_DATA_GRANTS = 4,
    parameter int CNT_W           = 3
) (
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] consec,
    output logic [1:0]       pick
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_GRANTS);
    localparam logic             GUARD_ON = (MAX_DATA_GRANTS != 0);

    logic force_inst;

    assign force_inst = inst_req && GUARD_ON && (consec == MAX_CNT);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves pick
        // unassigned; otherwise synthesis infers a latch.
        pick = OWN_NONE;
        if (data_req && !force_inst) begin
            pick = OWN_DATA;
        end else if (inst_req) begin
            pick = OWN_INST;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
// Merges the instruction and data sram-like request streams onto a single
// sram-like master port (feeding the AXI bridge). One transaction is
// outstanding at a time. Zero added latency when idle: the winner's request
// is presented combinationally and its addr_ok is returned in the same cycle
// the bridge accepts.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   inst_* / data_*  (in)            : requester req, wr, size, addr, wdata
//   inst_* / data_*  (out)           : addr_ok, data_ok, rdata back to requesters
//   m_req, m_wr, m_size, m_addr,
//   m_wdata          (out)           : merged master request
//   m_addr_ok, m_data_ok, m_rdata    : handshakes/data from the bridge
// While rst is high every output except the rdata pass-throughs is forced to 0.
// -----------------------------------------------------------------------------
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_DATA_GRANTS = 4,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_GRANTS);

    logic [1:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] consec_q, consec_d;

    logic [1:0] pick;
    logic [1:0] sel;
    logic       req_c;
    logic       inst_aok_c, data_aok_c, inst_dok_c, data_dok_c;
    sram_cmd_t  inst_cmd, data_cmd, m_cmd;

    assign inst_cmd = make_cmd(inst_wr, inst_size, inst_addr, inst_wdata);
    assign data_cmd = make_cmd(data_wr, data_size, data_addr, data_wdata);

    sram_like_arb_pick #(
        .MAX_DATA_GRANTS (MAX_DATA_GRANTS),
        .CNT_W           (CNT_W)
    ) u_pick (
        .inst_req (inst_req),
        .data_req (data_req),
        .consec   (consec_q),
        .pick     (pick)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        consec_d   = consec_q;
        sel        = OWN_NONE;
        req_c      = 1'b0;
        inst_aok_c = 1'b0;
        data_aok_c = 1'b0;
        inst_dok_c = 1'b0;
        data_dok_c = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                sel   = pick;
                req_c = inst_req | data_req;
                if (pick != OWN_NONE) begin
                    owner_d    = pick;
                    state_d    = m_addr_ok ? ARB_DATA : ARB_REQ;
                    inst_aok_c = m_addr_ok && (pick == OWN_INST);
                    data_aok_c = m_addr_ok && (pick == OWN_DATA);
                    // Only data wins taken over a waiting inst count toward
                    // the starvation guard; any other grant restarts it.
                    if (pick == OWN_DATA && inst_req) begin
                        consec_d = (consec_q == MAX_CNT) ? consec_q
                                                         : consec_q + CNT_W'(1);
                    end else begin
                        consec_d = '0;
                    end
                end
            end
            ARB_REQ: begin
                // Grant is locked to the owner until the bridge accepts.
                sel   = owner_q;
                req_c = 1'b1;
                if (m_addr_ok) begin
                    inst_aok_c = (owner_q == OWN_INST);
                    data_aok_c = (owner_q == OWN_DATA);
                    state_d    = ARB_DATA;
                end
            end
            ARB_DATA: begin
                sel = owner_q;
                if (m_data_ok) begin
                    inst_dok_c = (owner_q == OWN_INST);
                    data_dok_c = (owner_q == OWN_DATA);
                    owner_d    = OWN_NONE;
                    state_d    = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Request fields are driven only while a request is on the bus.
    always_comb begin
        m_cmd = '0;
        if (req_c && !rst) begin
            case (sel)
                OWN_INST: m_cmd = inst_cmd;
                OWN_DATA: m_cmd = data_cmd;
                default:  m_cmd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_NONE;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            consec_q <= consec_d;
        end
    end

    assign m_req        = req_c & ~rst;
    assign m_wr         = m_cmd.wr;
    assign m_size       = m_cmd.size;
    assign m_addr       = m_cmd.addr;
    assign m_wdata      = m_cmd.wdata;

    assign inst_addr_ok = inst_aok_c & ~rst;
    assign data_addr_ok = data_aok_c & ~rst;
    assign inst_data_ok = inst_dok_c & ~rst;
    assign data_data_ok = data_dok_c & ~rst;

    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
// Bench for sram_like_arbiter. u_dut uses MAX_DATA_GRANTS=4; u_dut0 sees the
// same stimulus with MAX_DATA_GRANTS=0. Inputs are driven on the falling edge
// and outputs compared 1 ns later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_0100;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;
    localparam logic [31:0] RD = 32'h1234_5678;
    localparam int          MAXG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;

    logic        inst_addr_ok_z, inst_data_ok_z, data_addr_ok_z, data_data_ok_z;
    logic [31:0] inst_rdata_z, data_rdata_z;
    logic        m_req_z, m_wr_z;
    logic [1:0]  m_size_z;
    logic [31:0] m_addr_z, m_wdata_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_DATA_GRANTS(4), .CNT_W(3)) u_dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    sram_like_arbiter #(.MAX_DATA_GRANTS(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok_z), .inst_data_ok(inst_data_ok_z), .inst_rdata(inst_rdata_z),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_z), .data_data_ok(data_data_ok_z), .data_rdata(data_rdata_z),
        .m_req(m_req_z), .m_wr(m_wr_z), .m_size(m_size_z), .m_addr(m_addr_z), .m_wdata(m_wdata_z),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // All non-rdata outputs of both arbiters must be 0.
    task automatic check_quiet(input string name);
        check({name, " m_req"},   {31'd0, m_req},   32'd0);
        check({name, " m_wr"},    {31'd0, m_wr},    32'd0);
        check({name, " m_size"},  {30'd0, m_size},  32'd0);
        check({name, " m_addr"},  m_addr,           32'd0);
        check({name, " m_wdata"}, m_wdata,          32'd0);
        check({name, " hs"}, {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
        check({name, " z m_bus"}, {m_req_z, m_wr_z, m_size_z, 28'd0} | m_addr_z | m_wdata_z, 32'd0);
        check({name, " z hs"}, {28'd0, inst_addr_ok_z, inst_data_ok_z, data_addr_ok_z, data_data_ok_z}, 32'd0);
        check({name, " z rdata"}, inst_rdata_z ^ data_rdata_z ^ m_rdata, m_rdata);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = IA; inst_wdata = 32'd0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = DA; data_wdata = WD;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle_inputs();
        @(negedge clk);
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #1 check_quiet("reset held");
        @(negedge clk);
        rst = 0; idle_inputs();
        #1 check_quiet("after reset");
    endtask

    typedef struct {
        bit ireq, dreq, dwr, maok, mdok;
        logic [31:0] rdata;
        bit e_mreq;
        logic [31:0] e_addr;
        bit e_mwr;
        logic [31:0] e_wdata;
        bit e_ia, e_id, e_da, e_dd;
    } vec_t;

    function automatic vec_t v(bit ireq, bit dreq, bit dwr, bit maok, bit mdok, logic [31:0] rdata,
                               bit emreq, logic [31:0] eaddr, bit emwr, logic [31:0] ewdata,
                               bit ia, bit id, bit da, bit dd);
        vec_t r;
        r.ireq = ireq; r.dreq = dreq; r.dwr = dwr; r.maok = maok; r.mdok = mdok; r.rdata = rdata;
        r.e_mreq = emreq; r.e_addr = eaddr; r.e_mwr = emwr; r.e_wdata = ewdata;
        r.e_ia = ia; r.e_id = id; r.e_da = da; r.e_dd = dd;
        return r;
    endfunction

    // Behavioural reference state for the random phase.
    int mo_owner;   // 0 none, 1 inst, 2 data
    bit mo_acc;     // owner's address already accepted
    int mo_streak;  // data wins taken while inst was waiting

    task automatic new_inst();
        inst_req = 1; inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom; inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_req = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wdata = $urandom;
    endtask

    initial begin
        vec_t tbl[23];
        rst = 1;
        idle_inputs();

        // ---------------- directed table ----------------
        //            ireq dreq dwr maok mdok rdata  mreq addr wr wdata  ia id da dd
        tbl[0]  = v(1, 0, 0, 1, 0, 32'd0, 1, IA, 0, 32'd0, 1, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 1, 0, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);
        tbl[2]  = v(0, 0, 0, 1, 0, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 1, 1, RD,    0, 0,  0, 32'd0, 0, 1, 0, 0);
        tbl[4]  = v(0, 0, 0, 0, 0, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);
        tbl[5]  = v(1, 1, 0, 1, 0, 32'd0, 1, DA, 0, WD,    0, 0, 1, 0);
        tbl[6]  = v(1, 0, 0, 1, 1, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 1);
        tbl[7]  = v(1, 0, 0, 1, 0, 32'd0, 1, IA, 0, 32'd0, 1, 0, 0, 0);
        tbl[8]  = v(0, 0, 0, 0, 1, RD,    0, 0,  0, 32'd0, 0, 1, 0, 0);
        tbl[9]  = v(1, 0, 0, 0, 0, 32'd0, 1, IA, 0, 32'd0, 0, 0, 0, 0);
        tbl[10] = v(1, 1, 0, 0, 0, 32'd0, 1, IA, 0, 32'd0, 0, 0, 0, 0);
        tbl[11] = v(1, 1, 0, 0, 0, 32'd0, 1, IA, 0, 32'd0, 0, 0, 0, 0);
        tbl[12] = v(1, 1, 0, 0, 0, 32'd0, 1, IA, 0, 32'd0, 0, 0, 0, 0);
        tbl[13] = v(1, 1, 0, 1, 0, 32'd0, 1, IA, 0, 32'd0, 1, 0, 0, 0);
        tbl[14] = v(0, 1, 0, 1, 0, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);
        tbl[15] = v(0, 1, 0, 0, 1, RD,    0, 0,  0, 32'd0, 0, 1, 0, 0);
        tbl[16] = v(0, 1, 0, 1, 0, 32'd0, 1, DA, 0, WD,    0, 0, 1, 0);
        tbl[17] = v(0, 0, 0, 0, 1, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 1);
        tbl[18] = v(0, 1, 1, 0, 0, 32'd0, 1, DA, 1, WD,    0, 0, 0, 0);
        tbl[19] = v(0, 1, 1, 1, 0, 32'd0, 1, DA, 1, WD,    0, 0, 1, 0);
        tbl[20] = v(0, 0, 0, 0, 1, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 1);
        tbl[21] = v(0, 0, 0, 0, 1, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);
        tbl[22] = v(0, 0, 0, 1, 0, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            inst_req = tbl[i].ireq; data_req = tbl[i].dreq; data_wr = tbl[i].dwr;
            m_addr_ok = tbl[i].maok; m_data_ok = tbl[i].mdok; m_rdata = tbl[i].rdata;
            #1;
            check($sformatf("tbl[%0d] m_req", i), {31'd0, m_req}, {31'd0, tbl[i].e_mreq});
            if (tbl[i].e_mreq) begin
                check($sformatf("tbl[%0d] m_addr", i), m_addr, tbl[i].e_addr);
                check($sformatf("tbl[%0d] m_wr", i), {31'd0, m_wr}, {31'd0, tbl[i].e_mwr});
                check($sformatf("tbl[%0d] m_wdata", i), m_wdata, tbl[i].e_wdata);
            end
            check($sformatf("tbl[%0d] handshakes", i),
                  {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok},
                  {28'd0, tbl[i].e_ia, tbl[i].e_id, tbl[i].e_da, tbl[i].e_dd});
            check($sformatf("tbl[%0d] inst_rdata", i), inst_rdata, tbl[i].rdata);
        end

        // ---------------- starvation guard ----------------
        // Bridge accepts and completes immediately: one grant every 2 cycles.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
            #1;
            check($sformatf("starve c%0d inst grant", c), {31'd0, inst_addr_ok},
                  {31'd0, (c % 2 == 0) && ((c / 2) % 5 == 4)});
            check($sformatf("starve c%0d data grant", c), {31'd0, data_addr_ok},
                  {31'd0, (c % 2 == 0) && ((c / 2) % 5 != 4)});
            check($sformatf("nogrd c%0d inst grant", c), {31'd0, inst_addr_ok_z}, 32'd0);
            check($sformatf("nogrd c%0d data grant", c), {31'd0, data_addr_ok_z},
                  {31'd0, c % 2 == 0});
        end

        // ---------------- reset while in DATA ----------------
        do_reset();
        @(negedge clk);
        data_req = 1; m_addr_ok = 1;
        #1 check("rstdata grant", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk);
        idle_inputs(); rst = 1;
        #1 check_quiet("rst in DATA");
        @(negedge clk);
        m_data_ok = 1;
        #1 check_quiet("rst held 2");
        @(negedge clk);
        rst = 0;
        #1 check_quiet("late data_ok");
        @(negedge clk);
        m_data_ok = 0; inst_req = 1; m_addr_ok = 1;
        #1;
        check("post-rst inst aok", {31'd0, inst_addr_ok}, 32'd1);
        check("post-rst m_addr", m_addr, IA);
        @(negedge clk);
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = RD;
        #1;
        check("post-rst inst dok", {31'd0, inst_data_ok}, 32'd1);
        check("post-rst rdata", inst_rdata, RD);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        mo_owner = 0; mo_acc = 0; mo_streak = 0;
        begin
            bit inst_done = 0, data_done = 0;
            for (int c = 0; c < 3000; c++) begin
                bit e_mreq, e_ia, e_da, e_id, e_dd;
                int sel;
                @(negedge clk);
                // Requesters hold until addr_ok, then may re-request at once.
                if (inst_req ? inst_done : ($urandom_range(0, 2) == 0)) begin
                    if (!inst_req || $urandom_range(0, 1) == 1) new_inst(); else inst_req = 0;
                end
                if (data_req ? data_done : ($urandom_range(0, 2) == 0)) begin
                    if (!data_req || $urandom_range(0, 1) == 1) new_data(); else data_req = 0;
                end
                m_addr_ok = 1'($urandom_range(0, 1));
                m_data_ok = ($urandom_range(0, 4) < 2);
                m_rdata   = $urandom;
                #1;
                e_mreq = 0; e_ia = 0; e_da = 0; e_id = 0; e_dd = 0; sel = 0;
                if (mo_owner == 0) begin
                    e_mreq = inst_req | data_req;
                    if (data_req && !(inst_req && mo_streak >= MAXG)) sel = 2;
                    else if (inst_req) sel = 1;
                    if (sel != 0) begin
                        e_ia = (sel == 1) && m_addr_ok;
                        e_da = (sel == 2) && m_addr_ok;
                        if (sel == 2 && inst_req) mo_streak = (mo_streak < MAXG) ? mo_streak + 1 : MAXG;
                        else mo_streak = 0;
                        mo_owner = sel;
                        mo_acc = m_addr_ok;
                    end
                end else if (!mo_acc) begin
                    sel = mo_owner;
                    e_mreq = 1;
                    e_ia = (sel == 1) && m_addr_ok;
                    e_da = (sel == 2) && m_addr_ok;
                    mo_acc = m_addr_ok;
                end else begin
                    e_id = (mo_owner == 1) && m_data_ok;
                    e_dd = (mo_owner == 2) && m_data_ok;
                    if (m_data_ok) begin
                        mo_owner = 0;
                        mo_acc = 0;
                    end
                end
                check($sformatf("rnd%0d m_req", c), {31'd0, m_req}, {31'd0, e_mreq});
                if (e_mreq) begin
                    check($sformatf("rnd%0d m_addr", c), m_addr, sel == 2 ? data_addr : inst_addr);
                    check($sformatf("rnd%0d m_wdata", c), m_wdata, sel == 2 ? data_wdata : inst_wdata);
                    check($sformatf("rnd%0d m_wr/size", c), {29'd0, m_wr, m_size},
                          sel == 2 ? {29'd0, data_wr, data_size} : {29'd0, inst_wr, inst_size});
                end
                check($sformatf("rnd%0d handshakes", c),
                      {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok},
                      {28'd0, e_ia, e_id, e_da, e_dd});
                check($sformatf("rnd%0d rdata", c), inst_rdata | data_rdata, m_rdata);
                inst_done = e_ia;
                data_done = e_da;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
